fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 5-stage RISC-V core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word into the IF/ID register. That registered word is the fetch-side instruction consumed by the hazard detection unit.
- Honours the load-use `hazard_stall` from hazard detection and the taken-branch/jump redirect from ID/EX; squashes wrong-path instructions with a NOP bubble.

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and registers the
// fetched word for decode. Redirect flushes IF/ID with a NOP bubble and
// takes priority over the load-use stall.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters;
// when undefined, both counter ports are tied to zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INSR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_insr,
  output logic [31:0] if_insr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_insr_q, if_insr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;

  // Next-state selection: redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_d       = pc_q;
    if_insr_d  = if_insr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (redirect) begin
      pc_d       = redirect_pc & ~32'h00000003;
      if_insr_d  = NOP_INSR;
      if_pc_d    = pc_q;
      if_valid_d = 1'b0;
    end else if (!hazard_stall) begin
      pc_d       = pc_q + 32'd4;
      if_insr_d  = imem_insr;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
    end
  end

  // PC and IF/ID register, asynchronously reset to a bubble at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_insr_q  <= NOP_INSR;
      if_pc_q    <= 32'h00000000;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_insr_q  <= if_insr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_insr   = if_insr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters of stalled cycles and taken redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h00000000;
      flush_cnt_q <= 32'h00000000;
    end else begin
      if (redirect && (flush_cnt_q != 32'hFFFFFFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (hazard_stall && !redirect && (stall_cnt_q != 32'hFFFFFFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h00000000;
  assign flush_cnt = 32'h00000000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: scoreboard of expected IF/ID state pushed when
// stimulus is driven and popped after each rising edge, plus per-scenario
// directed checks. A second instance exercises PC wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFFFFF8;

  logic        clk;
  logic        rst_n;
  logic        hazard_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_insr;
  logic [31:0] if_insr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_insr;
  logic [31:0] w_if_insr;
  logic [31:0] w_if_pc;
  logic        w_if_valid;
  logic [31:0] w_stall_cnt;
  logic [31:0] w_flush_cnt;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insr;
    logic [31:0] ifPc;
    logic        valid;
    logic [31:0] stallC;
    logic [31:0] flushC;
  } exp_t;

  exp_t sbQ[$];

  logic [31:0] mPc, mInsr, mIfPc, mStall, mFlush;
  logic        mValid;

  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  assign imem_insr   = imemWord(imem_addr);
  assign w_imem_insr = imemWord(w_imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_insr(imem_insr),
    .if_insr(if_insr), .if_pc(if_pc), .if_valid(if_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fetch_stage #(.RESET_PC(WRAP_RESET_PC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .hazard_stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h00000000), .imem_addr(w_imem_addr), .imem_insr(w_imem_insr),
    .if_insr(w_if_insr), .if_pc(w_if_pc), .if_valid(w_if_valid),
    .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Assert reset asynchronously, reset the model, release on a falling edge.
  task automatic applyReset();
    hazard_stall = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    rst_n        = 1'b0;
    #1;
    mPc = 32'h0; mInsr = NOP; mIfPc = 32'h0; mValid = 1'b0;
    mStall = 32'h0; mFlush = 32'h0;
    sbQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: model predicts, scoreboard compares after the edge.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    hazard_stall = st;
    redirect     = rd;
    redirect_pc  = rpc;
    if (rd) begin
      mIfPc = mPc; mInsr = NOP; mValid = 1'b0;
      mPc = {rpc[31:2], 2'b00};
      mFlush = mFlush + 32'd1;
    end else if (st) begin
      mStall = mStall + 32'd1;
    end else begin
      mInsr = imemWord(mPc); mIfPc = mPc; mValid = 1'b1;
      mPc = mPc + 32'd4;
    end
    e.addr = mPc; e.insr = mInsr; e.ifPc = mIfPc; e.valid = mValid;
`ifdef FETCH_PERF_CNT_EN
    e.stallC = mStall; e.flushC = mFlush;
`else
    e.stallC = 32'h0; e.flushC = 32'h0;
`endif
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    nChecks++;
    if (imem_addr !== e.addr) begin
      nFails++; $display("[TB] FAIL sb_addr got=%h exp=%h", imem_addr, e.addr);
    end
    nChecks++;
    if (if_insr !== e.insr) begin
      nFails++; $display("[TB] FAIL sb_insr got=%h exp=%h", if_insr, e.insr);
    end
    nChecks++;
    if (if_pc !== e.ifPc) begin
      nFails++; $display("[TB] FAIL sb_if_pc got=%h exp=%h", if_pc, e.ifPc);
    end
    nChecks++;
    if (if_valid !== e.valid) begin
      nFails++; $display("[TB] FAIL sb_valid got=%b exp=%b", if_valid, e.valid);
    end
    nChecks++;
    if (stall_cnt !== e.stallC) begin
      nFails++; $display("[TB] FAIL sb_stall_cnt got=%0d exp=%0d", stall_cnt, e.stallC);
    end
    nChecks++;
    if (flush_cnt !== e.flushC) begin
      nFails++; $display("[TB] FAIL sb_flush_cnt got=%0d exp=%0d", flush_cnt, e.flushC);
    end
  endtask

  task automatic test_reset();
    applyReset();
    nChecks++;
    if (imem_addr !== 32'h0) begin nFails++; $display("[TB] FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    nChecks++;
    if (if_insr !== NOP) begin nFails++; $display("[TB] FAIL reset_insr got=%h exp=%h", if_insr, NOP); end
    nChecks++;
    if (if_pc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_if_pc got=%h exp=0", if_pc); end
    nChecks++;
    if (if_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got=%b exp=0", if_valid); end
    nChecks++;
    if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      nFails++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] expPc [3];
    expPc[0] = 32'h0; expPc[1] = 32'h4; expPc[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      nChecks++;
      if (if_pc !== expPc[i] || if_valid !== 1'b1 || if_insr !== (expPc[i] ^ 32'hC0DE0000)) begin
        nFails++;
        $display("[TB] FAIL seq_%0d got pc=%h v=%b insr=%h exp pc=%h", i, if_pc, if_valid, if_insr, expPc[i]);
      end
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (imem_addr !== 32'h10) begin nFails++; $display("[TB] FAIL stall_pre_addr got=%h exp=10", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      nChecks++;
      if (imem_addr !== 32'h10 || if_pc !== 32'hC) begin
        nFails++; $display("[TB] FAIL stall_hold_%0d got addr=%h if_pc=%h exp 10/c", i, imem_addr, if_pc);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (imem_addr !== 32'h14 || if_pc !== 32'h10) begin
      nFails++; $display("[TB] FAIL stall_release got addr=%h if_pc=%h exp 14/10", imem_addr, if_pc);
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (imem_addr !== 32'h20) begin nFails++; $display("[TB] FAIL redir_pre_addr got=%h exp=20", imem_addr); end
    applyStimulus(1'b0, 1'b1, 32'h103);
    nChecks++;
    if (imem_addr !== 32'h100 || if_insr !== NOP || if_valid !== 1'b0 || if_pc !== 32'h20) begin
      nFails++; $display("[TB] FAIL redir_bubble got addr=%h insr=%h v=%b pc=%h", imem_addr, if_insr, if_valid, if_pc);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (if_insr !== 32'hC0DE0100 || if_pc !== 32'h100 || if_valid !== 1'b1) begin
      nFails++; $display("[TB] FAIL redir_target got insr=%h pc=%h v=%b exp c0de0100/100/1", if_insr, if_pc, if_valid);
    end
  endtask

  task automatic test_redirect_beats_stall();
    applyStimulus(1'b1, 1'b1, 32'h40);
    nChecks++;
    if (imem_addr !== 32'h40 || if_valid !== 1'b0 || if_insr !== NOP) begin
      nFails++; $display("[TB] FAIL redir_vs_stall got addr=%h v=%b insr=%h exp 40/0/13", imem_addr, if_valid, if_insr);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (if_pc !== 32'h40 || imem_addr !== 32'h44) begin
      nFails++; $display("[TB] FAIL redir_vs_stall_next got if_pc=%h addr=%h exp 40/44", if_pc, imem_addr);
    end
  endtask

  task automatic test_wrap();
    applyReset();
    nChecks++;
    if (w_imem_addr !== 32'hFFFFFFF8) begin nFails++; $display("[TB] FAIL wrap_0 got=%h exp=fffffff8", w_imem_addr); end
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (w_imem_addr !== 32'hFFFFFFFC) begin nFails++; $display("[TB] FAIL wrap_1 got=%h exp=fffffffc", w_imem_addr); end
    applyStimulus(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (w_imem_addr !== 32'h0 || w_if_pc !== 32'hFFFFFFFC) begin
      nFails++; $display("[TB] FAIL wrap_2 got addr=%h if_pc=%h exp 0/fffffffc", w_imem_addr, w_if_pc);
    end
  endtask

  task automatic test_perf_counters();
    logic [31:0] expS, expF;
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h80);
    applyStimulus(1'b1, 1'b1, 32'h204);
`ifdef FETCH_PERF_CNT_EN
    expS = 32'd5; expF = 32'd2;
`else
    expS = 32'd0; expF = 32'd0;
`endif
    hazard_stall = 1'b1;
    redirect     = 1'b0;
    #2;
    nChecks++;
    if (stall_cnt !== expS || flush_cnt !== expF) begin
      nFails++; $display("[TB] FAIL perf_before got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, expS, expF);
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0 || if_insr !== NOP) begin
      nFails++; $display("[TB] FAIL perf_async_reset got addr=%h v=%b insr=%h", imem_addr, if_valid, if_insr);
    end
    nChecks++;
    if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      nFails++; $display("[TB] FAIL perf_after got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    applyReset();
  endtask

  task automatic test_back_to_back();
    logic st, rd;
    for (int i = 0; i < 40; i++) begin
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 5) == 0);
      applyStimulus(st, rd, $urandom());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    hazard_stall = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    $display("[TB] starting fetch_stage bench");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_beats_stall();
    test_wrap();
    test_perf_counters();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
